// File: rtl/jogo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jogo_pkg                                                     |
// | Description : Shared game definitions: block FSM state encoding, game     |
// |               status values, move counter width, screen limit defaults.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package jogo_pkg;

    // Width of the move-timing counter
    localparam int c_CONT_W = 24;

    // Default screen limits for the enemy block
    localparam int c_X_MIN_DEF   = 8;
    localparam int c_X_MAX_DEF   = 120;
    localparam int c_Y_START_DEF = 10;
    localparam int c_Y_LIMIT_DEF = 100;

    // Enemy block FSM state encoding
    localparam logic [1:0] c_ST_MOVE_H    = 2'd0;
    localparam logic [1:0] c_ST_MOVE_DOWN = 2'd1;
    localparam logic [1:0] c_ST_DONE      = 2'd2;

    // Game status reported by the engine
    typedef enum logic [1:0] {
        JOGO_RODANDO = 2'd0,
        JOGO_VITORIA = 2'd1,
        JOGO_DERROTA = 2'd2
    } estado_jogo_t;

    // Clamp a 9-bit coordinate result into the 8-bit screen range
    function automatic logic [7:0] sat8(input logic [8:0] v);
        return v[8] ? 8'hFF : v[7:0];
    endfunction

endpackage : jogo_pkg
`default_nettype wire

// File: rtl/conta_vivos.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conta_vivos                                                  |
// | Description : Combinational population count of the enemy alive mask.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module conta_vivos #(
    parameter int N_ENEMY = 6
) (
    input  logic [N_ENEMY-1:0]           enemy_vivos,
    output logic [$clog2(N_ENEMY+1)-1:0] vivos
);

    localparam int c_W = $clog2(N_ENEMY + 1);

    // Sum the alive bits one by one
    always_comb begin
        vivos = '0;
        for (int i = 0; i < N_ENEMY; i++) begin
            vivos = vivos + c_W'(enemy_vivos[i]);
        end
    end

endmodule : conta_vivos
`default_nettype wire

// File: rtl/bloco_inimigos.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bloco_inimigos                                               |
// | Description : Enemy block motion controller. Walks the block side to side,|
// |               steps it down at each wall and flags the enemy win once the |
// |               block reaches Y_LIMIT.                                       |
// | Config      : define BLOCO_ACCEL_EN to scale the move delay with the      |
// |               number of enemies still alive (default: fixed delay).      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bloco_inimigos
    import jogo_pkg::*;
#(
    parameter int N_ENEMY         = 6,
    parameter int X_MIN           = c_X_MIN_DEF,
    parameter int X_MAX           = c_X_MAX_DEF,
    parameter int Y_START         = c_Y_START_DEF,
    parameter int Y_LIMIT         = c_Y_LIMIT_DEF,
    parameter int STEP_X          = 2,
    parameter int STEP_Y          = 4,
    parameter int MIN_DELAY       = 100000,
    parameter int DELAY_PER_ENEMY = 150000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               restart,
    input  logic [N_ENEMY-1:0] enemy_vivos,
    input  logic [1:0]         estado_jogo,
    output logic [7:0]         bloco_pos_X,
    output logic [7:0]         bloco_pos_Y,
    output logic               direcao,
    output logic               passo,
    output logic               vitoria_enemy
);

    localparam int c_VIVOS_W = $clog2(N_ENEMY + 1);

    logic [1:0]          r_state;
    logic [c_CONT_W-1:0] r_contador;
    logic [7:0]          r_x;
    logic [7:0]          r_y;
    logic                r_dir;
    logic                r_passo;
    logic                r_vitoria;

    logic [c_VIVOS_W-1:0] w_vivos;
    logic [c_CONT_W-1:0]  w_delay;
    logic                 w_run;
    logic                 w_move;
    logic [8:0]           w_x_mais;
    logic [7:0]           w_x_menos;
    logic [8:0]           w_y_mais;
    logic                 w_bate_dir;
    logic                 w_bate_esq;
    logic                 w_chega_fim;

    conta_vivos #(
        .N_ENEMY     (N_ENEMY)
    ) u_conta_vivos (
        .enemy_vivos (enemy_vivos),
        .vivos       (w_vivos)
    );

`ifdef BLOCO_ACCEL_EN
    // Fewer enemies alive means a shorter wait between moves
    always_comb begin
        w_delay = c_CONT_W'(MIN_DELAY)
                + c_CONT_W'(w_vivos) * c_CONT_W'(DELAY_PER_ENEMY);
    end
`else
    localparam logic [c_CONT_W-1:0] c_DELAY_FIX =
        c_CONT_W'(MIN_DELAY + N_ENEMY * DELAY_PER_ENEMY);

    // Fixed move period regardless of how many enemies remain
    always_comb begin
        w_delay = c_DELAY_FIX;
    end
`endif

    // Move timing and 9-bit boundary arithmetic
    always_comb begin
        w_run       = (estado_jogo == JOGO_RODANDO) && (w_vivos != '0)
                      && (r_state != c_ST_DONE);
        // >= so a kill that shrinks the delay below the count moves at once
        w_move      = w_run && (r_contador >= w_delay);
        w_x_mais    = {1'b0, r_x} + 9'(STEP_X);
        w_x_menos   = r_x - 8'(STEP_X);
        w_y_mais    = {1'b0, r_y} + 9'(STEP_Y);
        w_bate_dir  = (w_x_mais > 9'(X_MAX));
        w_bate_esq  = ({1'b0, r_x} < 9'(X_MIN + STEP_X));
        w_chega_fim = (w_y_mais >= 9'(Y_LIMIT));
    end

    // Block FSM, position, direction and move counter
    always_ff @(posedge clk) begin
        if (!reset || restart) begin
            r_state    <= c_ST_MOVE_H;
            r_contador <= '0;
            r_x        <= 8'(X_MIN);
            r_y        <= 8'(Y_START);
            r_dir      <= 1'b1;
            r_passo    <= 1'b0;
            r_vitoria  <= 1'b0;
        end else begin
            r_passo <= 1'b0;
            if (w_move) begin
                r_passo    <= 1'b1;
                r_contador <= '0;
                case (r_state)
                    c_ST_MOVE_H: begin
                        if (r_dir) begin
                            if (w_bate_dir) begin
                                r_state <= c_ST_MOVE_DOWN;
                            end else begin
                                r_x <= sat8(w_x_mais);
                            end
                        end else begin
                            if (w_bate_esq) begin
                                r_state <= c_ST_MOVE_DOWN;
                            end else begin
                                r_x <= w_x_menos;
                            end
                        end
                    end
                    c_ST_MOVE_DOWN: begin
                        r_y   <= sat8(w_y_mais);
                        r_dir <= ~r_dir;
                        if (w_chega_fim) begin
                            r_state   <= c_ST_DONE;
                            r_vitoria <= 1'b1;
                        end else begin
                            r_state <= c_ST_MOVE_H;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end else if (w_run) begin
                r_contador <= r_contador + c_CONT_W'(1);
            end
        end
    end

    assign bloco_pos_X   = r_x;
    assign bloco_pos_Y   = r_y;
    assign direcao       = r_dir;
    assign passo         = r_passo;
    assign vitoria_enemy = r_vitoria;

endmodule : bloco_inimigos
`default_nettype wire

// File: doc/bloco_inimigos.md
BLOCO_INIMIGOS -- requirements
Module: bloco_inimigos

Interface
REQ-001 SHALL have parameter N_ENEMY, default 6, meaning number of enemies (width of enemy_vivos).
REQ-002 SHALL have parameter X_MIN, default 8, meaning leftmost legal block X.
REQ-003 SHALL have parameter X_MAX, default 120, meaning rightmost legal block X.
REQ-004 SHALL have parameter Y_START, default 10, meaning block Y after reset or restart.
REQ-005 SHALL have parameter Y_LIMIT, default 100, meaning Y at or beyond which enemies win.
REQ-006 SHALL have parameters STEP_X (default 2) and STEP_Y (default 4), meaning pixel step per horizontal and per down move.
REQ-007 SHALL have parameters MIN_DELAY (default 100000) and DELAY_PER_ENEMY (default 150000), meaning clocks between moves.
REQ-008 SHALL have port clk, input, 1 bit, meaning the single system clock; every flop is on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit, meaning reset, synchronous and active-low.
REQ-010 SHALL have port restart, input, 1 bit, meaning active-high game restart from engine; behaves as reset.
REQ-011 SHALL have port enemy_vivos, input, N_ENEMY bits, meaning alive mask, bit i = enemy i alive.
REQ-012 SHALL have port estado_jogo, input, 2 bits, meaning 0 running, 1 player won, 2 player lost.
REQ-013 SHALL have ports bloco_pos_X and bloco_pos_Y, output, 8 bits each, meaning block top-left position.
REQ-014 SHALL have port direcao, output, 1 bit, meaning 1 = moving right, 0 = moving left.
REQ-015 SHALL have port passo, output, 1 bit, meaning one-cycle pulse in the cycle the position updates.
REQ-016 SHALL have port vitoria_enemy, output, 1 bit, meaning block has reached Y_LIMIT; sticky.

Function
REQ-017 SHALL implement states MOVE_H, MOVE_DOWN, DONE; all outputs registered.
REQ-018 SHALL run 24-bit counter contador; it advances only when estado_jogo==0, enemy_vivos!=0 and state!=DONE; otherwise it holds.
REQ-019 SHALL produce a move when contador==delay: passo=1 that cycle, contador cleared to 0; delay per REQ-030.
REQ-020 SHALL, in MOVE_H with direcao=1, on a move: if X+STEP_X>X_MAX, leave X unchanged and go to MOVE_DOWN; else X+=STEP_X.
REQ-021 SHALL, in MOVE_H with direcao=0, on a move: if X<X_MIN+STEP_X, leave X unchanged and go to MOVE_DOWN; else X-=STEP_X.
REQ-022 SHALL, in MOVE_DOWN, on the next move: Y+=STEP_Y, invert direcao; if new Y>=Y_LIMIT go to DONE, else MOVE_H.
REQ-023 SHALL, in DONE, assert vitoria_enemy and freeze position, direcao and contador until reset or restart.
REQ-024 SHALL compute X/Y arithmetic 9 bits wide; no wrap of bloco_pos_X/Y is permitted.
REQ-025 SHALL freeze entirely (no passo) while enemy_vivos==0 and resume from held count if an enemy becomes alive.
REQ-026 SHALL apply a delay change caused by a kill from the next comparison; if contador>delay after a kill, move on the next cycle.

Reset
REQ-027 SHALL, on reset==0 or restart==1 at a clock edge: X=X_MIN, Y=Y_START, direcao=1, state MOVE_H, contador=0, passo=0, vitoria_enemy=0.
REQ-028 SHALL give reset/restart priority over every other event, including a coincident move or DONE transition.

Configuration
REQ-029 SHALL honour macro BLOCO_ACCEL_EN.
REQ-030 SHALL, with BLOCO_ACCEL_EN defined, use delay = MIN_DELAY + popcount(enemy_vivos)*DELAY_PER_ENEMY; without it, delay = MIN_DELAY + N_ENEMY*DELAY_PER_ENEMY (constant).

Structure
REQ-031 SHALL take state encoding, 24-bit counter width and screen limit defaults from shared package jogo_pkg.
REQ-032 SHALL place population count in sub-module conta_vivos (combinational, N_ENEMY in, clog2(N_ENEMY+1) out).

Verification (MIN_DELAY=4, DELAY_PER_ENEMY=2, X_MIN=8, X_MAX=14, STEP_X=2, Y_START=10, STEP_Y=4, Y_LIMIT=22)
REQ-033 SHALL verify: reset low, all alive -> X=8,Y=10,direcao=1; first passo 17 cycles after release, X=10.
REQ-034 SHALL verify: run from X=14 right -> next move X=14 hold, next Y=14,direcao=0, then X decreases 12,10,8.
REQ-035 SHALL verify: keep running -> Y reaches 22 -> vitoria_enemy=1, no further passo, counter held.
REQ-036 SHALL verify: with BLOCO_ACCEL_EN, enemy_vivos 6'b000001 -> passo period 7 cycles; without, stays 17.
REQ-037 SHALL verify: estado_jogo=2 or enemy_vivos=0 mid-count -> no passo; restart=1 coincident with a move -> reset values win.
